// File: rtl/cpeta_error_monitor_pkg.sv
// cpeta_mon_pkg: shared FSM states, default widths and pipeline depth for the CPETA error monitor
package cpeta_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} mon_state_t;
  localparam int CPETA_N = 16;
  localparam int CPETA_CNT_W = 32;
  localparam int CPETA_ACC_W = 48;
  localparam int CPETA_MON_LAT = 3;
endpackage

// File: rtl/cpeta_error_monitor_if.sv
// cpeta_error_monitor_if: control, sample stream and report bundle between a collector (master) and the monitor (slave)
interface cpeta_error_monitor_if
  import cpeta_mon_pkg::*;
#(
  parameter int N = CPETA_N,
  parameter int CNT_W = CPETA_CNT_W,
  parameter int ACC_W = CPETA_ACC_W
);
  logic start;
  logic [CNT_W-1:0] frame_len;
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] approx_sum;
  logic rpt_valid;
  logic rpt_ready;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] ed_sum;
  logic [N-1:0] max_ed;
  logic busy;
  modport master (
    output start, frame_len, in_valid, a, b, approx_sum, rpt_ready,
    input in_ready, rpt_valid, sample_cnt, err_cnt, ed_sum, max_ed, busy
  );
  modport slave (
    input start, frame_len, in_valid, a, b, approx_sum, rpt_ready,
    output in_ready, rpt_valid, sample_cnt, err_cnt, ed_sum, max_ed, busy
  );
endinterface

// File: rtl/cpeta_error_monitor_ed_calc.sv
// cpeta_ed_calc: exact N-bit sum (carry dropped) and its absolute distance from the approximate sum
module cpeta_ed_calc #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx_sum,
  output logic [N-1:0] ed
);
  logic [N-1:0] exact;
  assign exact = a + b;
  assign ed = exact >= approx_sum ? exact - approx_sum : approx_sum - exact;
endmodule

// File: rtl/cpeta_error_monitor.sv
// cpeta_error_monitor: frame-based error statistics for CPETA sums; define CPETA_MON_MAXED_EN to build the max_ed tracker
module cpeta_error_monitor
  import cpeta_mon_pkg::*;
#(
  parameter int N = CPETA_N,
  parameter int CNT_W = CPETA_CNT_W,
  parameter int ACC_W = CPETA_ACC_W
) (
  input logic clk,
  input logic rst,
  cpeta_error_monitor_if.slave bus
);
  mon_state_t state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] ed_sum;
  logic [ACC_W:0] ed_sum_ext;
  logic in_ready;
  logic rpt_valid;
  logic busy;
  logic go;
  logic accept;
  logic s1_valid;
  logic s2_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic [N-1:0] s1_approx;
  logic [N-1:0] ed;
  logic [N-1:0] s2_ed;

  assign go = state == IDLE && bus.start;
  assign accept = bus.in_valid && in_ready;
  assign ed_sum_ext = {1'b0, ed_sum} + {{(ACC_W + 1 - N){1'b0}}, s2_ed};

  // frame control: sample admission, drain of the pipeline and report handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      sample_cnt <= '0;
      in_ready <= 1'b0;
      rpt_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          len <= bus.frame_len;
          sample_cnt <= '0;
          busy <= 1'b1;
          state <= bus.frame_len == '0 ? REPORT : RUN;
          rpt_valid <= bus.frame_len == '0;
          in_ready <= bus.frame_len != '0;
        end
        RUN: if (accept) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          if (sample_cnt + CNT_W'(1) == len) begin
            in_ready <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: if (!s1_valid && !s2_valid) begin
          rpt_valid <= 1'b1;
          state <= REPORT;
        end
        REPORT: if (bus.rpt_ready) begin
          rpt_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // two-stage datapath: S1 holds the accepted sample, S2 holds its error distance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_approx <= '0;
      s2_ed <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1_a <= bus.a;
        s1_b <= bus.b;
        s1_approx <= bus.approx_sum;
      end
      if (s1_valid) s2_ed <= ed;
    end
  end

  cpeta_ed_calc #(.N(N)) u_ed_calc (
    .a(s1_a),
    .b(s1_b),
    .approx_sum(s1_approx),
    .ed(ed)
  );

  // error count and saturating distance sum, cleared when a new frame starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      ed_sum <= '0;
    end else if (go) begin
      err_cnt <= '0;
      ed_sum <= '0;
    end else if (s2_valid) begin
      err_cnt <= err_cnt + CNT_W'(s2_ed != '0);
      ed_sum <= ed_sum_ext[ACC_W] ? '1 : ed_sum_ext[ACC_W-1:0];
    end
  end

`ifdef CPETA_MON_MAXED_EN
  logic [N-1:0] max_ed;
  // running maximum of the error distance over the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_ed <= '0;
    else if (go) max_ed <= '0;
    else if (s2_valid && s2_ed > max_ed) max_ed <= s2_ed;
  end
  assign bus.max_ed = max_ed;
`else
  assign bus.max_ed = '0;
`endif

  assign bus.in_ready = in_ready;
  assign bus.rpt_valid = rpt_valid;
  assign bus.busy = busy;
  assign bus.sample_cnt = sample_cnt;
  assign bus.err_cnt = err_cnt;
  assign bus.ed_sum = ed_sum;
endmodule

// File: tb/tb_cpeta_error_monitor.sv
// tb_cpeta_error_monitor: table vectors plus scoreboarded per-sample and per-frame checks of the CPETA error monitor
module tb_cpeta_error_monitor;
  import cpeta_mon_pkg::*;
`ifdef CPETA_MON_MAXED_EN
  localparam bit MAXED = 1'b1;
`else
  localparam bit MAXED = 1'b0;
`endif
  localparam logic [63:0] SUM_MAX = 64'hFFFF_FFFF_FFFF;

  typedef struct { logic [15:0] ed; int due; } sb_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] ap; logic [15:0] ed; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;
  int first_acc = 0;
  int last_acc = 0;
  sb_t sb[$];
  sb_t e;
  vec_t tbl[4];
  logic [31:0] m_err = 0;
  logic [63:0] m_sum = 0;
  logic [15:0] m_max = 0;

  cpeta_error_monitor_if #(.N(16), .CNT_W(32), .ACC_W(48)) bus ();
  cpeta_error_monitor_if #(.N(16), .CNT_W(32), .ACC_W(17)) sbus ();

  cpeta_error_monitor #(.N(16), .CNT_W(32), .ACC_W(48)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  cpeta_error_monitor #(.N(16), .CNT_W(32), .ACC_W(17)) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] exp_max(input logic [15:0] m);
    return MAXED ? m : 16'h0;
  endfunction

  function automatic logic [15:0] ed_of(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ap);
    logic [15:0] ex;
    ex = a + b;
    return ex > ap ? ex - ap : ap - ex;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len);
    m_err = 0;
    m_sum = 0;
    m_max = 0;
    bus.frame_len = len;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ap, input logic [15:0] ed);
    bit ok = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.approx_sum = ap;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        sb.push_back('{ed: ed, due: cyc + 3});
        last_acc = cyc + 1;
      end
      step();
    end
    chk("sample_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_rpt(output int at);
    at = -1;
    for (int i = 0; i < 30 && at < 0; i++) begin
      if (bus.rpt_valid) at = cyc;
      else step();
    end
    chk("rpt_valid_arrives", 64'(bus.rpt_valid), 64'd1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_rpt_valid"}, 64'(bus.rpt_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_sample_cnt"}, 64'(bus.sample_cnt), 64'd0);
    chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'd0);
    chk({tag, "_ed_sum"}, 64'(bus.ed_sum), 64'd0);
    chk({tag, "_max_ed"}, 64'(bus.max_ed), 64'd0);
  endtask

  // scoreboard: each accepted sample's ED lands in the stats three edges after acceptance
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      m_err = m_err + 32'(e.ed != 16'h0);
      m_sum = (m_sum + 64'(e.ed) > SUM_MAX) ? SUM_MAX : m_sum + 64'(e.ed);
      if (e.ed > m_max) m_max = e.ed;
      chk("sb_err_cnt", 64'(bus.err_cnt), 64'(m_err));
      chk("sb_ed_sum", 64'(bus.ed_sum), m_sum);
      chk("sb_max_ed", 64'(bus.max_ed), 64'(exp_max(m_max)));
    end
  end

  initial begin
    int at;
    logic [15:0] ra, rb, rap;
    tbl[0] = '{16'h1234, 16'h0001, 16'h1235, 16'h0000};
    tbl[1] = '{16'h00F0, 16'h0010, 16'h00F0, 16'h0010};
    tbl[2] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
    tbl[3] = '{16'h0800, 16'h0800, 16'h1003, 16'h0003};
    {bus.start, bus.frame_len, bus.in_valid, bus.a, bus.b, bus.approx_sum, bus.rpt_ready} = '0;
    {sbus.start, sbus.frame_len, sbus.in_valid, sbus.a, sbus.b, sbus.approx_sum, sbus.rpt_ready} = '0;
    step();
    step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();

    // table frame with a bubble between the 2nd and 3rd sample
    do_start(32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b0;
        step();
      end
      send(tbl[i].a, tbl[i].b, tbl[i].ap, tbl[i].ed);
    end
    bus.in_valid = 1'b0;
    wait_rpt(at);
    chk("tbl_sample_cnt", 64'(bus.sample_cnt), 64'd4);
    chk("tbl_err_cnt", 64'(bus.err_cnt), 64'd2);
    chk("tbl_ed_sum", 64'(bus.ed_sum), 64'h13);
    chk("tbl_max_ed", 64'(bus.max_ed), 64'(exp_max(16'h0010)));
    bus.rpt_ready = 1'b1;
    step();
    bus.rpt_ready = 1'b0;
    chk("tbl_rpt_done", 64'(bus.rpt_valid), 64'd0);
    chk("tbl_busy_done", 64'(bus.busy), 64'd0);
    chk("tbl_err_held", 64'(bus.err_cnt), 64'd2);
    chk("tbl_sum_held", 64'(bus.ed_sum), 64'h13);

    // empty frame goes straight to REPORT; collector already ready
    bus.rpt_ready = 1'b1;
    do_start(32'd0);
    chk("empty_rpt_valid", 64'(bus.rpt_valid), 64'd1);
    chk("empty_in_ready", 64'(bus.in_ready), 64'd0);
    chk("empty_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    chk("empty_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("empty_ed_sum", 64'(bus.ed_sum), 64'd0);
    chk("empty_max_ed", 64'(bus.max_ed), 64'd0);
    step();
    chk("empty_rpt_done", 64'(bus.rpt_valid), 64'd0);
    chk("empty_busy_done", 64'(bus.busy), 64'd0);
    chk("empty_in_ready2", 64'(bus.in_ready), 64'd0);
    bus.rpt_ready = 1'b0;

    // back-to-back random frame, then report held for 10 cycles
    do_start(32'd8);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rap = (ra + rb) ^ ((i % 3 == 0) ? 16'h0 : 16'($urandom_range(1, 255)));
      send(ra, rb, rap, ed_of(ra, rb, rap));
      if (i == 0) first_acc = last_acc;
    end
    bus.in_valid = 1'b0;
    chk("b2b_span", 64'(last_acc - first_acc), 64'd7);
    chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd1);
    chk("drain_no_rpt", 64'(bus.rpt_valid), 64'd0);
    wait_rpt(at);
    chk("rpt_latency", 64'(at - last_acc), 64'(CPETA_MON_LAT));
    for (int i = 0; i < 10; i++) begin
      chk("hold_rpt_valid", 64'(bus.rpt_valid), 64'd1);
      chk("hold_sample_cnt", 64'(bus.sample_cnt), 64'd8);
      chk("hold_err_cnt", 64'(bus.err_cnt), 64'(m_err));
      chk("hold_ed_sum", 64'(bus.ed_sum), m_sum);
      chk("hold_max_ed", 64'(bus.max_ed), 64'(exp_max(m_max)));
      step();
    end
    bus.rpt_ready = 1'b1;
    step();
    bus.rpt_ready = 1'b0;
    chk("b2b_rpt_done", 64'(bus.rpt_valid), 64'd0);
    chk("b2b_cnt_held", 64'(bus.sample_cnt), 64'd8);

    // reset in the middle of a frame discards everything
    do_start(32'd10);
    for (int i = 0; i < 5; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rap = (ra + rb) ^ 16'h0001;
      send(ra, rb, rap, 16'h0001);
    end
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    sb.delete();
    chk_idle_zero("midreset");
    step();
    rst = 1'b0;
    step();
    chk_idle_zero("post_reset");
    do_start(32'd2);
    send(tbl[1].a, tbl[1].b, tbl[1].ap, tbl[1].ed);
    send(tbl[3].a, tbl[3].b, tbl[3].ap, tbl[3].ed);
    bus.in_valid = 1'b0;
    wait_rpt(at);
    chk("rerun_sample_cnt", 64'(bus.sample_cnt), 64'd2);
    chk("rerun_err_cnt", 64'(bus.err_cnt), 64'd2);
    chk("rerun_ed_sum", 64'(bus.ed_sum), 64'h13);
    chk("rerun_max_ed", 64'(bus.max_ed), 64'(exp_max(16'h0010)));
    bus.rpt_ready = 1'b1;
    step();
    bus.rpt_ready = 1'b0;

    // saturation on a 17-bit accumulator: three samples of ED 0xFFFF
    sbus.frame_len = 32'd3;
    sbus.start = 1'b1;
    step();
    sbus.start = 1'b0;
    sbus.a = 16'hFFFF;
    sbus.b = 16'h0000;
    sbus.approx_sum = 16'h0000;
    sbus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sat_in_ready", 64'(sbus.in_ready), 64'd1);
      step();
    end
    sbus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !sbus.rpt_valid; i++) step();
    chk("sat_rpt_valid", 64'(sbus.rpt_valid), 64'd1);
    chk("sat_sample_cnt", 64'(sbus.sample_cnt), 64'd3);
    chk("sat_err_cnt", 64'(sbus.err_cnt), 64'd3);
    chk("sat_ed_sum", 64'(sbus.ed_sum), 64'h1FFFF);
    chk("sat_max_ed", 64'(sbus.max_ed), 64'(exp_max(16'hFFFF)));
    sbus.rpt_ready = 1'b1;
    step();
    sbus.rpt_ready = 1'b0;
    chk("sat_rpt_done", 64'(sbus.rpt_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
